conv2d_stream: RTL and testbench

- Streaming 3x3 2D convolution engine. Next generation of the single-shot conv2d block.
- Accepts a raster-scan pixel stream over a valid/ready handshake and buffers two image rows internally.
- Emits one "valid-mode" (no padding) output per full 3x3 window, also over valid/ready.
- Image size, pixel width and coefficient width are parameters. Coefficients are signed and loaded at run time. One result per cycle at full throughput.

---
 rtl/conv2d_pkg.sv | 24 ++
 rtl/conv2d_line_buffer.sv | 54 +++++
 rtl/conv2d_stream.sv | 158 +++++++++++++++
 tb/tb_conv2d_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared types and constants for the streaming 3x3 convolver.
//   state_t    - frame controller states
//   K, TAPS    - kernel edge length and tap count
//   acc_width  - default signed accumulator width for given pixel/coef widths
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned K    = 3;
  localparam int unsigned TAPS = K * K;

  // Nine products of (DATA_W+1)-bit unsigned-as-signed pixels and COEF_W-bit
  // coefficients need 4 growth bits beyond the product width minus one.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w);
    return data_w + coef_w + 4;
  endfunction

endpackage

// File: rtl/conv2d_line_buffer.sv
// conv2d_line_buffer: two row delay lines plus the 3x3 window registers.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   shift_en   - advance the window by one pixel (an accepted input pixel)
//   pix_in     - current pixel
//   win        - window, win[i][j] = P[r-2+i][c-2+j] after shifting in P[r][c]
module conv2d_line_buffer
  import conv2d_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] pix_in,
  output logic [DATA_W-1:0] win [K][K]
);

  // Each row memory is an IMG_W-deep delay line: its tail is the pixel
  // exactly one row above the one it feeds, so no column addressing is needed.
  logic [DATA_W-1:0] row1 [IMG_W];
  logic [DATA_W-1:0] row2 [IMG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < IMG_W; i++) begin
        row1[i] <= '0;
        row2[i] <= '0;
      end
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      row1[0] <= pix_in;
      row2[0] <= row1[IMG_W-1];
      for (int unsigned i = 1; i < IMG_W; i++) begin
        row1[i] <= row1[i-1];
        row2[i] <= row2[i-1];
      end
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[0][K-1] <= row2[IMG_W-1];
      win[1][K-1] <= row1[IMG_W-1];
      win[2][K-1] <= pix_in;
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 valid-mode convolution over a raster pixel stream.
// Optional build macro CONV2D_STREAM_RELU_EN: clamp negative sums to zero.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   start                        - begin a frame (IDLE only)
//   coef_we, coef_idx, coef_data - kernel tap write (IDLE only, idx 0..8 row-major)
//   in_valid, in_ready, in_data  - pixel stream in
//   out_valid, out_ready, out_data - signed result stream out
//   busy                         - frame in progress (RUN or DRAIN)
//   done                         - one-cycle pulse after the last result
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned ACC_W  = acc_width(DATA_W, COEF_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     coef_we,
  input  logic [3:0]               coef_idx,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t                     state;
  logic [COL_W-1:0]           col;
  logic [ROW_W-1:0]           row;
  logic signed [COEF_W-1:0]   coef [TAPS];
  logic [DATA_W-1:0]          win  [K][K];
  logic signed [PROD_W-1:0]   prod [TAPS];
  logic                       win_valid;
  logic                       p_valid;
  logic signed [ACC_W-1:0]    sum;
  logic                       stall;
  logic                       accept;
  logic                       at_window;
  logic                       last_pix;
  logic                       last_hs;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = (state == RUN) && !stall;
  assign accept    = in_valid && in_ready;
  assign at_window = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  // The final pixel always completes a window, so once everything upstream
  // is empty the result being handed off is the last of the frame.
  assign last_hs   = out_valid && out_ready && !p_valid && !win_valid;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  conv2d_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .pix_in   (in_data),
    .win      (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row != ROW_LAST) row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (state == IDLE && coef_we && 32'(coef_idx) < TAPS) begin
      coef[coef_idx] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) prod[k] <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        prod[k] <= PROD_W'($signed({1'b0, win[k/K][k%K]})) * PROD_W'(coef[k]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      sum = sum + ACC_W'(prod[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      p_valid   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      win_valid <= accept && at_window;
      p_valid   <= win_valid;
      out_valid <= p_valid;
      if (p_valid) begin
`ifdef CONV2D_STREAM_RELU_EN
        out_data <= sum[ACC_W-1] ? '0 : sum;
`else
        out_data <= sum;
`endif
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed self-checking bench for conv2d_stream (5x5 image,
// 8-bit pixels and coefficients, 20-bit results).
module tb_conv2d_stream;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               coef_we;
  logic [3:0]         coef_idx;
  logic [7:0]         coef_data;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] out_data;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int pix   [25];
  int kern  [9];
  int exp_v [9];

  always #5 clk = ~clk;

  conv2d_stream #(
    .DATA_W (8),
    .COEF_W (8),
    .IMG_W  (5),
    .IMG_H  (5),
    .ACC_W  (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .coef_we   (coef_we),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  task automatic load_coefs();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_idx  = 4'(i);
      coef_data = 8'(kern[i]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic set_ramp_pixels();
    for (int i = 0; i < 25; i++) pix[i] = i + 1;
  endtask

  task automatic set_ones_expect();
    exp_v = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
  endtask

  // Streams one frame and checks each result against exp_v. sc_* writes a
  // coefficient in the start cycle; inject pulses start/coef_we mid-frame.
  task automatic run_frame(input string name, input bit use_bp, input bit inject,
                           input bit sc_en, input logic [3:0] sc_idx,
                           input logic [7:0] sc_data);
    int sent, got, cyc, dones, extra, first_cyc;
    bit prev_stall;
    logic signed [19:0] held;
    logic signed [19:0] e;
    logic [15:0] bp_pat;
    bp_pat = 16'b1011_0010_1101_0110;
    sent = 0; got = 0; cyc = 0; dones = 0; extra = 0; first_cyc = -1;
    prev_stall = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    if (sc_en) begin
      coef_we = 1'b1; coef_idx = sc_idx; coef_data = sc_data;
    end
    @(negedge clk);
    start = 1'b0; coef_we = 1'b0;
    while (got < 9 && cyc < 400) begin
      out_ready = use_bp ? bp_pat[4'(cyc % 16)] : 1'b1;
      in_valid  = (sent < 25);
      in_data   = (sent < 25) ? 8'(pix[sent]) : 8'd0;
      start = 1'b0; coef_we = 1'b0;
      if (inject && sent == 5) begin
        start = 1'b1; coef_we = 1'b1; coef_idx = 4'd4; coef_data = 8'hFB;
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_run: got %b expected 1", name, busy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== held) begin
          errors++; $display("FAIL %s stall_hold: got %0d expected %0d", name, out_data, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL %s stall_in_ready: got %b expected 0", name, in_ready);
        end
        held = out_data;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        e = 20'(exp_v[got]);
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL %s result%0d: got %0d expected %0d", name, got, out_data, e);
        end
        got++;
      end
      if (done) dones++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 9) begin
      errors++; $display("FAIL %s timeout: got %0d results expected 9", name, got);
    end
    checks++;
    if (sent != 25) begin
      errors++; $display("FAIL %s pixels_taken: got %0d expected 25", name, sent);
    end
    if (!use_bp) begin
      checks++;
      if (first_cyc != 15 || cyc != 28) begin
        errors++;
        $display("FAIL %s timing: got first=%0d end=%0d expected first=15 end=28", name, first_cyc, cyc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done) dones++;
      if (out_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d expected 1", name, dones);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL %s extra_results: got %0d expected 0", name, extra);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset flags: got %b expected 0000", {in_ready, out_valid, busy, done});
    end
    checks++;
    if (out_data !== 20'sd0) begin
      errors++; $display("FAIL reset out_data: got %0d expected 0", out_data);
    end
    rst = 1'b0;
  endtask

  // Last tap written in the same cycle as start must still land.
  task automatic test_ones();
    set_ramp_pixels();
    for (int i = 0; i < 9; i++) kern[i] = 1;
    kern[8] = 0;
    load_coefs();
    set_ones_expect();
    run_frame("ones", 1'b0, 1'b0, 1'b1, 4'd8, 8'd1);
  endtask

  task automatic test_centre();
    set_ramp_pixels();
    for (int i = 0; i < 9; i++) kern[i] = 0;
    kern[4] = -1;
    load_coefs();
`ifdef CONV2D_STREAM_RELU_EN
    exp_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_v = '{-7, -8, -9, -12, -13, -14, -17, -18, -19};
`endif
    run_frame("centre", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic test_max();
    for (int i = 0; i < 25; i++) pix[i] = 255;
    for (int i = 0; i < 9; i++) kern[i] = 127;
    load_coefs();
    for (int i = 0; i < 9; i++) exp_v[i] = 291465;
    run_frame("max", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic test_backpressure();
    set_ramp_pixels();
    for (int i = 0; i < 9; i++) kern[i] = 1;
    load_coefs();
    set_ones_expect();
    run_frame("backpressure", 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    int sent, cyc;
    set_ramp_pixels();
    for (int i = 0; i < 9; i++) kern[i] = 1;
    load_coefs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 12 && cyc < 100) begin
      in_valid = 1'b1;
      in_data  = 8'(pix[sent]);
      #1;
      if (in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (sent != 12 || busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre: got sent=%0d busy=%b in_ready=%b expected 12 1 1", sent, busy, in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid flags: got %b expected 0000", {in_ready, out_valid, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    // Coefficients were cleared, so an unloaded frame convolves to zero.
    for (int i = 0; i < 9; i++) exp_v[i] = 0;
    run_frame("cleared_coefs", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    load_coefs();
    set_ones_expect();
    run_frame("after_reset", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic test_ignored();
    set_ramp_pixels();
    for (int i = 0; i < 9; i++) kern[i] = 1;
    load_coefs();
    set_ones_expect();
    run_frame("run_ignores", 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    @(negedge clk);
    coef_we = 1'b1; coef_idx = 4'd15; coef_data = 8'd50;
    @(negedge clk);
    coef_we = 1'b0;
    run_frame("second_frame", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_ones();
    test_centre();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
